mul_iter_unit: RTL
==================

# mul_iter_unit

Iterative, parametrised integer multiplier for the RISC-V M-extension datapath. It executes MUL, MULH, MULHSU and MULHU on XLEN-bit operands over multiple cycles, retiring RADIX bits of the multiplier per cycle. It replaces single-cycle combinational multiplication in the execute stage and presents valid/ready handshakes on both sides. It supports a zero-operand fast path and a pipeline-flush kill.

## Interface
- XLEN, 64: operand width; 32 or 64.
- RADIX, 1: multiplier bits retired per cycle; one of 1, 2, 4; must divide XLEN.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- kill  input  1  abort the in-flight operation.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  architectural result selected by op.
- result_full  output  2*XLEN  full product under op signedness.

## Operation
- States are IDLE, CALC, SIGN and DONE.
- **Accept.** An operation is accepted on a clock edge where in_valid && in_ready.
  - Latch op.
  - Latch |a| and |b| as XLEN-bit unsigned magnitudes.
  - Latch neg = sign(a) XOR sign(b).
- **Signedness.**
  - a is signed for MUL, MULH and MULHSU.
  - b is signed for MUL and MULH only.
  - Unsigned operands pass through unchanged; their sign contributes 0 to neg.
  - MUL low bits are identical either way.
- **Zero fast path.** If a==0 or b==0 at accept, go directly to DONE with result_full=0.
- **IDLE -> CALC.** Otherwise go to CALC with:
  - accumulator = 0;
  - step counter = XLEN/RADIX - 1.
- **CALC.** Each cycle adds |a| times the low RADIX bits of the remaining multiplier into a 2*XLEN+RADIX-bit accumulator, then shifts the multiplier right by RADIX.
  - When the counter reaches 0, go to SIGN.
- **SIGN.** The product is the unsigned 2*XLEN-bit magnitude product.
  - If neg, result_full = two's complement of the product, modulo 2^(2*XLEN).
  - Go to DONE.
- **DONE.**
  - out_valid=1.
  - result = result_full[XLEN-1:0] for MUL, result_full[2*XLEN-1:XLEN] otherwise.
  - On out_ready, go to IDLE.
- **Magnitude edge case.** |-2^(XLEN-1)| = 2^(XLEN-1) must be represented as an unsigned magnitude, not re-signed.
- **kill.**
  - In any state, kill forces IDLE at the next edge.
  - out_valid drops; no result is produced.
  - kill overrides a simultaneous out_ready.
  - If kill and in_valid are both high in IDLE, nothing is accepted.
- **Reset.** rst overrides everything, including mid-CALC.
  - Outputs after reset: state=IDLE, in_ready=1, out_valid=0, result=0, result_full=0.
- **Output stability.** result and result_full are stable while out_valid && !out_ready.

## Timing
- Let N = XLEN/RADIX. The accept edge is edge 0.
- **Normal path.**
  - CALC occupies cycles 1..N.
  - SIGN occupies cycle N+1.
  - out_valid is high from cycle N+2.
  - Latency is N+2 cycles: 66 for XLEN=64, RADIX=1; 18 for RADIX=4.
  - SIGN is taken unconditionally, so latency is data-independent.
- **Zero fast path.** out_valid is high in cycle 1; latency is 1.
- **Back-to-back issue.**
  - in_ready rises in the cycle after the out_valid && out_ready edge.
  - No same-cycle accept while in DONE.
  - Throughput is one operation per N+3 cycles when out_ready is held high.
- **Handshake signals.** in_ready and out_valid are registered-state decodes, not combinational on in_valid/out_ready.

## Test plan
- **Signed MUL / MULH.** XLEN=64, RADIX=1, op=MUL, a=-3, b=7 -> after 66 cycles:
  - result = 0xFFFF_FFFF_FFFF_FFEB;
  - result_full = -21 sign-extended to 128 bits.
  - Same operands with op=MULH -> result = 0xFFFF_FFFF_FFFF_FFFF.
- **Most-negative operands.** a=b=0x8000_0000_0000_0000:
  - MULH -> 0x4000_0000_0000_0000.
  - MULHU -> 0x4000_0000_0000_0000.
  - MULHSU -> 0xC000_0000_0000_0000.
  - MUL -> 0.
- **Zero fast path.** op=MULHU, a=0, b=0xFFFF_FFFF_FFFF_FFFF -> out_valid in cycle 1, result=0. Then hold out_ready=0 for 5 cycles: out_valid and result remain stable.
- **kill mid-operation.** Assert kill in CALC cycle 10 -> IDLE next cycle, out_valid never rises, in_ready=1. A following MUL 5×6 returns 30 with normal latency.
- **Reset mid-operation.** Assert rst in CALC cycle 30 -> all outputs at reset values the next cycle, in_ready=1. Also assert rst while DONE is stalled -> out_valid=0.
- **Randomised, all radices.** RADIX ∈ {1,2,4} with random out_ready backpressure, 10k random operands across all ops -> results match the reference product; latency is exactly N+2 for nonzero operands and 1 for zero operands.

Source files
------------

// File: rtl/mul_iter_unit_if.sv
// rtl/mul_iter_unit_if.sv - handshake bundle for the iterative multiplier
interface mul_iter_unit_if #(
    parameter int XLEN = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic              kill;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;
    logic [2*XLEN-1:0] result_full;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, result_full
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, result_full
    );
endinterface

// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - radix-2^RADIX shift-add multiplier for MUL/MULH/MULHSU/MULHU
module mul_iter_unit #(
    parameter int XLEN  = 64,
    parameter int RADIX = 1
) (
    input logic           clk,
    input logic           rst,
    mul_iter_unit_if.slave bus
);
    localparam int N  = XLEN / RADIX;
    localparam int CW = $clog2(N);
    localparam int AW = 2 * XLEN + RADIX;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] full_q, full_d;

    logic                  a_neg, b_neg;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic [RADIX-1:0]      digit;
    logic [XLEN+RADIX-1:0] pprod, acc_hi_sum;
    logic                  accept;

    // Unary minus on the raw XLEN bits keeps |-2^(XLEN-1)| as an unsigned 2^(XLEN-1).
    always_comb begin
        a_neg  = (bus.op != OP_MULHU) && bus.a[XLEN-1];
        b_neg  = ((bus.op == OP_MUL) || (bus.op == OP_MULH)) && bus.b[XLEN-1];
        a_mag  = a_neg ? -bus.a : bus.a;
        b_mag  = b_neg ? -bus.b : bus.b;
        accept = bus.in_valid && (state_q == S_IDLE) && !bus.kill;
    end

    // Partial product lands at bit XLEN, then the whole accumulator shifts right by RADIX.
    always_comb begin
        digit      = mplier_q[RADIX-1:0];
        pprod      = {{RADIX{1'b0}}, mcand_q} * {{XLEN{1'b0}}, digit};
        acc_hi_sum = acc_q[AW-1:XLEN] + pprod;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        full_d   = full_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d     = bus.op;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = CW'(N - 1);
                    if ((bus.a == '0) || (bus.b == '0)) begin
                        full_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d    = {acc_hi_sum, acc_q[XLEN-1:0]} >> RADIX;
                mplier_d = mplier_q >> RADIX;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_SIGN;
            end
            S_SIGN: begin
                full_d  = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.kill) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            full_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.result_full = full_q;
    assign bus.result      = (op_q == OP_MUL) ? full_q[XLEN-1:0] : full_q[2*XLEN-1:XLEN];
endmodule
